// File: rtl/nibble_serial_sub_ctrl.sv
// Wide subtractor D = A - B - Bin evaluated one nibble per clock through a
// shared 4-bit ripple slice, with borrow carried between nibbles in a register.

module nibble_sub_slice (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       bin,
   output logic [3:0] diff,
   output logic       bout
);
   logic [4:0] res;

   // The fifth bit of the widened difference goes high exactly when a < b + bin.
   assign res  = {1'b0, a} - {1'b0, b} - {4'b0000, bin};
   assign diff = res[3:0];
   assign bout = res[4];
endmodule

module nibble_serial_sub_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [4*NIBBLES-1:0] A,
   input  logic [4*NIBBLES-1:0] B,
   input  logic                 Bin,
   output logic                 busy,
   output logic                 done,
   output logic [4*NIBBLES-1:0] D,
   output logic                 Bout,
   output logic                 Zero
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = $clog2(NIBBLES + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic            brw_q, brw_d;
   logic [W-1:0]    d_q, d_d;
   logic            bout_q, bout_d;
   logic            zero_q, zero_d;

   logic [3:0]      sl_a, sl_b, sl_diff;
   logic            sl_bout;
   logic [W-1:0]    d_ins;
   logic            last;

   nibble_sub_slice u_slice (
      .a    (sl_a),
      .b    (sl_b),
      .bin  (brw_q),
      .diff (sl_diff),
      .bout (sl_bout)
   );

   // Operand nibble selection and result nibble insertion at the current index.
   always_comb begin
      sl_a  = 4'h0;
      sl_b  = 4'h0;
      d_ins = d_q;
      for (int i = 0; i < NIBBLES; i++) begin
         if (idx_q == IW'(i)) begin
            sl_a             = a_q[4*i +: 4];
            sl_b             = b_q[4*i +: 4];
            d_ins[4*i +: 4]  = sl_diff;
         end
      end
   end

   assign last = (idx_q == IW'(NIBBLES - 1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      brw_d   = brw_q;
      d_d     = d_q;
      bout_d  = bout_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               brw_d   = Bin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            d_d   = d_ins;
            brw_d = sl_bout;
            if (last) begin
               bout_d  = sl_bout;
               zero_d  = (d_ins == '0);
               state_d = DONE;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         brw_q   <= 1'b0;
         d_q     <= '0;
         bout_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         brw_q   <= brw_d;
         d_q     <= d_d;
         bout_q  <= bout_d;
         zero_q  <= zero_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign D    = d_q;
   assign Bout = bout_q;
   assign Zero = zero_q;
endmodule

// File: tb/tb_nibble_serial_sub_ctrl.sv
// Self-checking bench for nibble_serial_sub_ctrl with NIBBLES=4 (16-bit operands).

module tb_nibble_serial_sub_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [15:0] A, B;
   logic        Bin;
   logic        busy, done;
   logic [15:0] D;
   logic        Bout, Zero;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   nibble_serial_sub_ctrl #(.NIBBLES(4)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .Bin   (Bin),
      .busy  (busy),
      .done  (done),
      .D     (D),
      .Bout  (Bout),
      .Zero  (Zero)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        bin;
      logic [15:0] d;
      logic        bout;
      logic        zero;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference: full-width subtraction at 17 bits.
   task automatic model(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        output logic [15:0] d, output logic bout, output logic zero);
      int unsigned lhs, rhs;
      lhs  = a;
      rhs  = b + bin;
      d    = 16'((lhs - rhs) & 32'hFFFF);
      bout = (lhs < rhs);
      zero = (d == 16'h0);
   endtask

   // Issue one op, wait for done, report result, latency and busy duration.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic bin,
                        output logic [15:0] d, output logic bout, output logic zero,
                        output int lat, output int bcnt);
      @(negedge clk);
      A = a; B = b; Bin = bin; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 0; bcnt = 0;
      while (!done && lat < 20) begin
         if (busy) bcnt++;
         @(negedge clk);
         lat++;
      end
      if (busy) bcnt++;
      d = D; bout = Bout; zero = Zero;
      @(negedge clk);
      chk("done_one_cycle", {31'b0, done}, 32'd0);
      chk("busy_low_after", {31'b0, busy}, 32'd0);
   endtask

   logic [15:0] rd, ed, ra, rb;
   logic        rbo, rz, ebo, ez, rbin;
   int          lat, bcnt, ndone, guard;

   initial begin
      tbl[0] = '{16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0};
      tbl[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      tbl[2] = '{16'h8000, 16'h0000, 1'b1, 16'h7FFF, 1'b0, 1'b0};
      tbl[3] = '{16'hABCD, 16'hABCD, 1'b0, 16'h0000, 1'b0, 1'b1};
      tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      tbl[5] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      tbl[6] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
      tbl[7] = '{16'h0000, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 1'b0};
      tbl[8] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0};
      tbl[9] = '{16'h0001, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1};

      rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_D",    {16'b0, D},    32'd0);
      chk("rst_Bout", {31'b0, Bout}, 32'd0);
      chk("rst_Zero", {31'b0, Zero}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         do_op(tbl[i].a, tbl[i].b, tbl[i].bin, rd, rbo, rz, lat, bcnt);
         chk($sformatf("tbl%0d_D", i),    {16'b0, rd},  {16'b0, tbl[i].d});
         chk($sformatf("tbl%0d_Bout", i), {31'b0, rbo}, {31'b0, tbl[i].bout});
         chk($sformatf("tbl%0d_Zero", i), {31'b0, rz},  {31'b0, tbl[i].zero});
         chk($sformatf("tbl%0d_lat", i),  lat,  32'd4);
         chk($sformatf("tbl%0d_busy", i), bcnt, 32'd5);
      end

      // Result holds while idle.
      repeat (3) @(negedge clk);
      chk("hold_D", {16'b0, D}, {16'b0, tbl[9].d});
      chk("hold_Zero", {31'b0, Zero}, {31'b0, tbl[9].zero});

      // Start and operand changes during RUN are ignored.
      @(negedge clk);
      A = 16'h1234; B = 16'h0034; Bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; A = 16'hFFFF; B = 16'h1111; Bin = 1'b1;
      guard = 0;
      while (!done && guard < 20) begin @(negedge clk); guard++; end
      chk("ign_guard", {31'b0, done}, 32'd1);
      chk("ign_D", {16'b0, D}, 32'h1200);
      chk("ign_Bout", {31'b0, Bout}, 32'd0);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("ign_no_reaccept", {31'b0, busy}, 32'd0);

      // Start held continuously: one accept per IDLE visit, one done per op.
      A = 16'hABCD; B = 16'h0BCD; Bin = 1'b0; start = 1'b1;
      ndone = 0;
      for (int c = 0; c < 24; c++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            chk("b2b_D", {16'b0, D}, 32'hA000);
         end
      end
      chk("b2b_ndone", ndone, 32'd4);
      start = 1'b0;
      guard = 0;
      while (busy && guard < 20) begin @(negedge clk); guard++; end
      chk("b2b_drain", {31'b0, busy}, 32'd0);

      // Reset at edge 2 of a run aborts without a done.
      @(negedge clk);
      A = 16'h0000; B = 16'h0001; Bin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_D",    {16'b0, D},    32'd0);
      chk("abort_Bout", {31'b0, Bout}, 32'd0);
      rst = 1'b0;
      do_op(16'h0005, 16'h0003, 1'b0, rd, rbo, rz, lat, bcnt);
      chk("post_rst_D", {16'b0, rd}, 32'h0002);
      chk("post_rst_lat", lat, 32'd4);

      // Randomized ops against the reference.
      for (int r = 0; r < 40; r++) begin
         ra = 16'($urandom); rb = 16'($urandom); rbin = 1'($urandom);
         if (r % 8 == 0) rb = ra;
         model(ra, rb, rbin, ed, ebo, ez);
         do_op(ra, rb, rbin, rd, rbo, rz, lat, bcnt);
         chk($sformatf("rnd%0d_D", r),    {16'b0, rd},  {16'b0, ed});
         chk($sformatf("rnd%0d_Bout", r), {31'b0, rbo}, {31'b0, ebo});
         chk($sformatf("rnd%0d_Zero", r), {31'b0, rz},  {31'b0, ez});
         chk($sformatf("rnd%0d_lat", r),  lat, 32'd4);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
